// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and the bit-period helper
// used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit, integer-truncated.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. Full/empty come from the registered level;
// a pop never frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a sync_fifo and are shifted
// out LSB first on a registered, idle-high line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          rs232_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           line_q, line_d;

  logic           fifo_pop, fifo_full, fifo_empty, baud_done;
  logic [7:0]     fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state_q != IDLE) || (fifo_level != '0);
  assign rs232_tx  = line_q;
  assign baud_done = (baud_q == CW'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Line level is decoded from the upcoming state so the pin is a flop.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10: per-byte frame table plus
// back-to-back, full-FIFO and mid-frame reset sequences.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, rs232_tx, tx_busy;
  logic [3:0] fifo_level;

  uart_tx_fifo #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rs232_tx   (rs232_tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [9:0] mon_frames[$];
  int         mon_starts[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (tx_busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  // Line monitor: samples each frame at bit centres (5 cycles into each bit).
  initial begin
    logic [9:0] fb;
    int         s;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && rs232_tx === 1'b0) begin
        s = cyc;
        repeat (5) @(posedge clk);
        #1;
        fb[0] = rs232_tx;
        for (int i = 1; i < 10; i++) begin
          repeat (10) @(posedge clk);
          #1;
          fb[i] = rs232_tx;
        end
        mon_frames.push_back(fb);
        mon_starts.push_back(s);
      end
    end
  end

  initial begin
    int         n, maxl, nacc, waits, lows;
    logic [9:0] f;
    logic [9:0] b2b_exp[3];

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};
    b2b_exp[0] = 10'b1000000000;
    b2b_exp[1] = 10'b1111111110;
    b2b_exp[2] = 10'b1010101010;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_line",  {31'd0, rs232_tx}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy",  {31'd0, tx_busy},  32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_quiet", {25'd0, rs232_tx, tx_ready, tx_busy, fifo_level}, 32'b1100000);
    end

    // Single-byte frames from the table.
    foreach (vecs[i]) begin
      mon_frames.delete();
      mon_starts.delete();
      tx_data  = vecs[i].data;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      chk("push_level", {28'd0, fifo_level}, 32'd1);
      chk("push_busy",  {31'd0, tx_busy},   32'd1);
      chk("push_line",  {31'd0, rs232_tx},  32'd1);
      tick();
      chk("start_line", {31'd0, rs232_tx},  32'd0);
      chk("pop_level",  {28'd0, fifo_level}, 32'd0);
      wait_idle(150, n);
      chk("frame_len", n, 100);
      chk("frame_count", mon_frames.size(), 1);
      if (mon_frames.size() > 0) begin
        f = mon_frames[0];
        chk("frame_bits", {22'd0, f}, {22'd0, vecs[i].frame});
      end
      tick();
    end

    // Three consecutive pushes -> contiguous frames.
    mon_frames.delete();
    mon_starts.delete();
    maxl = 0;
    tx_valid = 1'b1;
    tx_data = 8'h00; tick(); if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    tx_data = 8'hFF; tick(); if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    tx_data = 8'h55; tick(); if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    tx_valid = 1'b0;
    chk("b2b_peak", maxl, 2);
    wait_idle(400, n);
    chk("b2b_count", mon_frames.size(), 3);
    for (int k = 0; k < mon_frames.size() && k < 3; k++) begin
      f = mon_frames[k];
      chk("b2b_frame", {22'd0, f}, {22'd0, b2b_exp[k]});
      if (k > 0) chk("b2b_spacing", mon_starts[k] - mon_starts[k-1], 100);
    end
    tick();

    // Hold tx_valid high with incrementing data until the FIFO fills.
    mon_frames.delete();
    mon_starts.delete();
    nacc = 0;
    tx_valid = 1'b1;
    tx_data = 8'd1;
    n = 0;
    while (tx_ready === 1'b1 && n < 50) begin
      tick();
      nacc++;
      tx_data = 8'(nacc + 1);
      n++;
    end
    chk("fill_count", nacc, 9);
    chk("full_level", {28'd0, fifo_level}, 32'd8);
    chk("full_ready", {31'd0, tx_ready},   32'd0);
    waits = 0;
    while (tx_ready !== 1'b1 && waits < 200) begin
      tick();
      waits++;
    end
    chk("full_wait", waits, 93);
    chk("pop_at_full_level", {28'd0, fifo_level}, 32'd7);
    tick();
    nacc++;
    tx_valid = 1'b0;
    chk("push_after_pop_level", {28'd0, fifo_level}, 32'd8);
    wait_idle(1300, n);
    chk("hold_count", mon_frames.size(), nacc);
    for (int k = 0; k < mon_frames.size(); k++) begin
      f = mon_frames[k];
      chk("hold_frame", {22'd0, f}, {22'd0, 1'b1, 8'(k + 1), 1'b0});
      if (k > 0) chk("hold_spacing", mon_starts[k] - mon_starts[k-1], 100);
    end
    tick();

    // Reset during DATA bit 3 of 0x0F with four bytes queued.
    tx_valid = 1'b1;
    tx_data = 8'h0F; tick();
    tx_data = 8'h11; tick();
    tx_data = 8'h12; tick();
    tx_data = 8'h13; tick();
    tx_data = 8'h14; tick();
    tx_valid = 1'b0;
    chk("rst_queue_level", {28'd0, fifo_level}, 32'd4);
    repeat (41) tick();
    chk("bit3_line", {31'd0, rs232_tx}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_line",  {31'd0, rs232_tx},   32'd1);
    chk("abort_level", {28'd0, fifo_level}, 32'd0);
    chk("abort_busy",  {31'd0, tx_busy},    32'd0);
    chk("abort_ready", {31'd0, tx_ready},   32'd1);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("no_frame_after_rst", lows, 0);
    mon_frames.delete();
    mon_starts.delete();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_idle(150, n);
    chk("post_rst_count", mon_frames.size(), 1);
    if (mon_frames.size() > 0) begin
      f = mon_frames[0];
      chk("post_rst_frame", {22'd0, f}, {22'd0, 10'b1001111000});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter with integrated baud generation. Accepts bytes over a valid/ready handshake into an internal FIFO. Serialises each byte as 8N1 (one start bit, 8 data bits LSB first, one stop bit) on `rs232_tx`. Sits on the transmit side of the board's RS232 port: the outbound counterpart to the byte receiver, for sources that burst several bytes faster than the line drains them.

## Interface
- `CLK_HZ`, 50000000: input clock frequency in Hz.
- `BAUD`, 9600: line rate. Bit period `DIV = CLK_HZ / BAUD`, integer-truncated (5208 at defaults). `DIV` must be ≥ 2.
- `FIFO_DEPTH`, 8: byte buffer depth. Must be a power of two, ≥ 2.
- `clk`  in  1: system clock, single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `tx_data`  in  8: byte to send, qualified by `tx_valid`.
- `tx_valid`  in  1: producer offers `tx_data`.
- `tx_ready`  out  1: FIFO can accept a byte this cycle.
- `rs232_tx`  out  1: serial line, idle high.
- `tx_busy`  out  1: high while the FIFO is non-empty or a frame is in progress.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of bytes buffered, excluding the byte being shifted.

## Operation
- Handshake: a byte is accepted on a rising edge where `tx_valid && tx_ready`.
  - `tx_ready = (fifo_level != FIFO_DEPTH)`, derived from the registered count.
  - `tx_data` may change freely when not accepted.
  - Producer may hold `tx_valid` high indefinitely.
- FSM states:
  - IDLE: line = 1. If FIFO non-empty: pop head into 8-bit shift register, clear bit counter, → START.
  - START: line = 0 for DIV cycles → DATA.
  - DATA: line = `shift[0]` for DIV cycles per bit. Shift right after each bit. After bit 7 → STOP.
  - STOP: line = 1 for DIV cycles. If FIFO non-empty: pop and → START directly (no idle gap). Otherwise → IDLE.
- `rs232_tx` is a registered output; no combinational path from state to pin.
- Baud counter counts 0..DIV-1 and restarts on every state entry. Width `$clog2(DIV)`.
- Simultaneous push and pop in the same cycle: `fifo_level` is unchanged and both operations take effect.
- FIFO full: `tx_ready`=0 and `tx_valid` is ignored. A pop in that cycle does not enable a same-cycle push.
- FIFO empty with an accepted push: the byte is available to the FSM on the next cycle.
- Pointer wrap: read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full/empty are decided by `fifo_level`, not by pointer compare.
- Reset, including mid-frame: frame aborts; line goes high at that edge; FIFO is flushed.
  - A truncated frame with no stop bit is acceptable on abort.
- `tx_busy = (state != IDLE) || (fifo_level != 0)`.

## Timing
- Reset values (after the first edge with `rst_n`=0): `rs232_tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_level`=0, state IDLE.
- Push accepted at edge k into an empty, idle block:
  - `fifo_level`=1 and `tx_busy`=1 after edge k.
  - Pop, START entry, `rs232_tx`=0 and `fifo_level`=0 after edge k+1.
- Frame length: exactly 10·DIV cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back bytes: the next start bit begins exactly 10·DIV cycles after the previous one.
- `tx_busy` falls on the edge where the state returns to IDLE, after the last stop bit.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum: IDLE, START, DATA, STOP.
  - Function `uart_div(clk_hz, baud)` returning `DIV`, shared with the receive side.
- Sub-module `sync_fifo`:
  - Parameters WIDTH=8, DEPTH.
  - Ports: push/pop, dout, level, full/empty.
  - Reusable elsewhere.
- FSM, baud counter and shift register live in `uart_tx_fifo`.

## Test plan
Bench parameters: CLK_HZ=1000, BAUD=100, giving DIV=10.
- Reset, no stimulus → `rs232_tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_level`=0 for 100 cycles.
- Push 0xA5 once → start bit after 2 edges; line samples at bit centres read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); `tx_busy` low after 100+2 cycles.
- Push 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous frames; start bits exactly 100 cycles apart; `fifo_level` peaks at 2.
- Hold `tx_valid` high with incrementing data 0x01.. → `tx_ready` drops when `fifo_level`=8. The 9th byte is accepted only after the next pop. All bytes are transmitted in order with none lost or duplicated.
- At full, with a pop in the same cycle as `tx_valid` → that byte is not accepted; it is accepted on the following cycle.
- Assert `rst_n`=0 during DATA bit 3 of 0x0F with 4 bytes queued → line high on that edge; `fifo_level`=0; no further frames after `rst_n` rises until a new push.
